// File: rtl/heap_level_ctrl.sv
// heap_level_ctrl: one level of a pipelined systolic heap sorter.
// Sifts INSERT values down and bubbles POP holes into the level below.

module heap_level_ctrl #(
  parameter int DATA_W    = 16,
  parameter int LEVEL     = 3,
  parameter int CNT_W     = 8,
  parameter int MIN_FIRST = 1,
  parameter int LEAF      = 0,
  localparam int AW = (LEVEL > 0) ? LEVEL : 1,
  localparam int WW = CNT_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              up_in_val,
  input  logic              up_in_op,
  input  logic [DATA_W-1:0] up_in,
  input  logic [AW-1:0]     up_in_addr,
  output logic              ready_out,
  output logic              idle_out,
  output logic [AW-1:0]     tm_addr,
  input  logic [WW-1:0]     tm_din,
  output logic [WW-1:0]     tm_dout,
  output logic              tm_we,
  output logic [AW-1:0]     lm_addr,
  input  logic [WW-1:0]     lm_din,
  output logic [AW-1:0]     rm_addr,
  input  logic [WW-1:0]     rm_din,
  output logic              low_out_val,
  output logic              low_out_op,
  output logic [DATA_W-1:0] low_out,
  output logic [LEVEL:0]    low_out_addr,
  input  logic              ready_in,
  input  logic              child_idle_in,
  output logic [DATA_W-1:0] pop_dout,
  output logic              pop_dout_val,
  output logic              ovf,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CMP,
    ISSUE
  } state_t;

  state_t state_q, state_d;

  logic              op_q;
  logic [DATA_W-1:0] in_q;
  logic [AW-1:0]     addr_q;
  logic              err_q;
  logic              lop_q;
  logic [DATA_W-1:0] lval_q;
  logic [LEVEL:0]    laddr_q;

  logic              accept;
  logic [CNT_W-1:0]  n_cnt, l_cnt, r_cnt;
  logic [CNT_W-1:0]  cnt_inc, cnt_dec;
  logic [DATA_W-1:0] n_val, l_val, r_val;
  logic [DATA_W-1:0] keep, lose;
  logic              in_win, pick_r;
  logic [AW:0]       la_full;

  logic [WW-1:0]     word_d;
  logic [DATA_W-1:0] fval_d;
  logic              we_d, fwd_d, fdir_d;
  logic              ovf_d, popv_d, err_set;

  // strict "a sorts ahead of b"; equal keys never win
  function automatic logic beats(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    beats = (MIN_FIRST != 0) ? (a < b) : (a > b);
  endfunction

  assign idle_out  = ~rst & (state_q == IDLE);
  assign ready_out = idle_out & child_idle_in;
  assign accept    = clk_en & up_in_val & ready_out;

  assign tm_addr = addr_q;
  assign lm_addr = addr_q;
  assign rm_addr = addr_q;

  assign n_cnt = tm_din[WW-1:DATA_W];
  assign n_val = tm_din[DATA_W-1:0];
  assign l_cnt = lm_din[WW-1:DATA_W];
  assign l_val = lm_din[DATA_W-1:0];
  assign r_cnt = rm_din[WW-1:DATA_W];
  assign r_val = rm_din[DATA_W-1:0];

  assign cnt_inc = n_cnt + CNT_W'(1);
  assign cnt_dec = n_cnt - CNT_W'(1);

  assign in_win = beats(in_q, n_val);
  assign keep   = in_win ? in_q : n_val;
  assign lose   = in_win ? n_val : in_q;
  assign pick_r = (r_cnt != '0) &&
                  ((l_cnt == '0) || beats(r_val, l_val));

  assign la_full = {addr_q, fdir_d};

  // next state plus the CMP-cycle node update and forward decision
  always_comb begin
    state_d = state_q;
    word_d  = tm_din;
    fval_d  = '0;
    we_d    = 1'b0;
    fwd_d   = 1'b0;
    fdir_d  = 1'b0;
    ovf_d   = 1'b0;
    popv_d  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RD;
      end
      RD: begin
        state_d = CMP;
      end
      CMP: begin
        if (!op_q) begin
          if (n_cnt == '0) begin
            word_d = {CNT_W'(1), in_q};
            we_d   = 1'b1;
          end else if (LEAF != 0) begin
            word_d = {n_cnt, keep};
            we_d   = in_win;
            ovf_d  = 1'b1;
          end else begin
            word_d = {cnt_inc, keep};
            we_d   = 1'b1;
            fwd_d  = 1'b1;
            fval_d = lose;
            fdir_d = (r_cnt < l_cnt);
          end
        end else begin
          popv_d = 1'b1;
          if (n_cnt == '0) begin
            err_set = 1'b1;
          end else if ((n_cnt == CNT_W'(1)) || (LEAF != 0)) begin
            word_d = {CNT_W'(0), n_val};
            we_d   = 1'b1;
          end else begin
            word_d = {cnt_dec, pick_r ? r_val : l_val};
            we_d   = 1'b1;
            fwd_d  = 1'b1;
            fdir_d = pick_r;
          end
        end
        state_d = fwd_d ? ISSUE : IDLE;
      end
      ISSUE: begin
        if (ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tm_we        = we_d & clk_en & ~rst;
  assign tm_dout      = tm_we ? word_d : '0;
  assign pop_dout_val = popv_d & clk_en & ~rst;
  assign pop_dout     = pop_dout_val ? n_val : '0;
  assign ovf          = ovf_d & clk_en & ~rst;
  assign err          = err_q;

  assign low_out_val  = (state_q == ISSUE);
  assign low_out_op   = lop_q;
  assign low_out      = lval_q;
  assign low_out_addr = laddr_q;

  // FSM state register, frozen while clk_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // request latch, forwarded-op bundle and sticky empty-pop error
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 1'b0;
      in_q    <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      lop_q   <= 1'b0;
      lval_q  <= '0;
      laddr_q <= '0;
    end else if (clk_en) begin
      if (accept) begin
        op_q   <= up_in_op;
        in_q   <= up_in;
        addr_q <= up_in_addr;
      end
      if (fwd_d) begin
        lop_q   <= op_q;
        lval_q  <= fval_d;
        laddr_q <= la_full[LEVEL:0];
      end
      if (err_set) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_heap_level_ctrl.sv
// tb_heap_level_ctrl: vectors, random ops vs a reference model,
// and hand sequences for stall, reset, error and leaf behaviour.

module tb_heap_level_ctrl;

  typedef struct {
    logic        op;
    logic [15:0] in;
    logic [2:0]  addr;
    logic [23:0] node;
    logic [23:0] lw;
    logic [23:0] rw;
    logic [23:0] word;
    logic        fwd;
    logic [15:0] fval;
    logic [3:0]  faddr;
    logic [15:0] pop;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        up_in_val;
  logic        up_in_op;
  logic [15:0] up_in;
  logic [2:0]  up_in_addr;
  logic        ready_out;
  logic        idle_out;
  logic [2:0]  tm_addr;
  logic [23:0] tm_din;
  logic [23:0] tm_dout;
  logic        tm_we;
  logic [2:0]  lm_addr;
  logic [23:0] lm_din;
  logic [2:0]  rm_addr;
  logic [23:0] rm_din;
  logic        low_out_val;
  logic        low_out_op;
  logic [15:0] low_out;
  logic [3:0]  low_out_addr;
  logic        ready_in;
  logic        child_idle_in;
  logic [15:0] pop_dout;
  logic        pop_dout_val;
  logic        ovf;
  logic        err;

  logic        b_up_in_val;
  logic        b_up_in_op;
  logic [15:0] b_up_in;
  logic [2:0]  b_up_in_addr;
  logic        b_ready_out;
  logic        b_idle_out;
  logic [2:0]  b_tm_addr;
  logic [23:0] b_tm_din;
  logic [23:0] b_tm_dout;
  logic        b_tm_we;
  logic [2:0]  b_lm_addr;
  logic [2:0]  b_rm_addr;
  logic        b_low_out_val;
  logic        b_low_out_op;
  logic [15:0] b_low_out;
  logic [3:0]  b_low_out_addr;
  logic [15:0] b_pop_dout;
  logic        b_pop_dout_val;
  logic        b_ovf;
  logic        b_err;

  logic [23:0] tm_mem [8];
  logic [23:0] lm_mem [8];
  logic [23:0] rm_mem [8];
  logic [23:0] b_mem  [8];
  logic        ld_en;
  logic [2:0]  ld_a;
  logic [23:0] ld_t, ld_l, ld_r;

  int total = 0;
  int bad   = 0;
  logic err_exp;

  int          o_we, o_popv, o_k;
  logic [23:0] o_word;
  logic        o_fwd, o_fop;
  logic [15:0] o_fval, o_pop;
  logic [3:0]  o_faddr;
  logic        o_unst, o_rbad, o_fbad;

  heap_level_ctrl u_dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .up_in_val(up_in_val), .up_in_op(up_in_op),
    .up_in(up_in), .up_in_addr(up_in_addr),
    .ready_out(ready_out), .idle_out(idle_out),
    .tm_addr(tm_addr), .tm_din(tm_din),
    .tm_dout(tm_dout), .tm_we(tm_we),
    .lm_addr(lm_addr), .lm_din(lm_din),
    .rm_addr(rm_addr), .rm_din(rm_din),
    .low_out_val(low_out_val), .low_out_op(low_out_op),
    .low_out(low_out), .low_out_addr(low_out_addr),
    .ready_in(ready_in), .child_idle_in(child_idle_in),
    .pop_dout(pop_dout), .pop_dout_val(pop_dout_val),
    .ovf(ovf), .err(err)
  );

  heap_level_ctrl #(.MIN_FIRST(0), .LEAF(1)) u_leaf (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .up_in_val(b_up_in_val), .up_in_op(b_up_in_op),
    .up_in(b_up_in), .up_in_addr(b_up_in_addr),
    .ready_out(b_ready_out), .idle_out(b_idle_out),
    .tm_addr(b_tm_addr), .tm_din(b_tm_din),
    .tm_dout(b_tm_dout), .tm_we(b_tm_we),
    .lm_addr(b_lm_addr), .lm_din(24'd0),
    .rm_addr(b_rm_addr), .rm_din(24'd0),
    .low_out_val(b_low_out_val), .low_out_op(b_low_out_op),
    .low_out(b_low_out), .low_out_addr(b_low_out_addr),
    .ready_in(1'b1), .child_idle_in(1'b1),
    .pop_dout(b_pop_dout), .pop_dout_val(b_pop_dout_val),
    .ovf(b_ovf), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    tm_din   <= tm_mem[tm_addr];
    lm_din   <= lm_mem[lm_addr];
    rm_din   <= rm_mem[rm_addr];
    b_tm_din <= b_mem[b_tm_addr];
    if (tm_we) tm_mem[tm_addr] <= tm_dout;
    if (b_tm_we) b_mem[b_tm_addr] <= b_tm_dout;
    if (ld_en) begin
      tm_mem[ld_a] <= ld_t;
      lm_mem[ld_a] <= ld_l;
      rm_mem[ld_a] <= ld_r;
      b_mem[ld_a]  <= ld_t;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [23:0] w(input int c, input int v);
    w = {c[7:0], v[15:0]};
  endfunction

  function automatic vec_t mk(
    input logic op, input int in, input int a,
    input logic [23:0] node, input logic [23:0] lw,
    input logic [23:0] rw, input logic [23:0] word,
    input logic fwd, input int fval, input int faddr,
    input int pop
  );
    vec_t t;
    t.op = op;  t.in = in[15:0];  t.addr = a[2:0];
    t.node = node;  t.lw = lw;  t.rw = rw;
    t.word = word;  t.fwd = fwd;  t.fval = fval[15:0];
    t.faddr = faddr[3:0];  t.pop = pop[15:0];
    return t;
  endfunction

  // min-heap reference: winner stays, ties keep the resident key
  function automatic void model(
    input logic op, input logic [15:0] in, input logic [2:0] a,
    input logic [23:0] nd, input logic [23:0] lw,
    input logic [23:0] rw,
    output logic [23:0] word, output logic fwd,
    output logic [15:0] fval, output logic [3:0] faddr,
    output logic [15:0] pop, output logic eset
  );
    int cnt, val, best;
    logic [23:0] ch [2];
    cnt = int'(nd[23:16]);
    val = int'(nd[15:0]);
    ch[0] = lw;
    ch[1] = rw;
    word = nd;  fwd = 0;  fval = 0;  faddr = 0;  pop = 0;  eset = 0;
    if (!op) begin
      if (cnt == 0) begin
        word = w(1, int'(in));
      end else begin
        fwd = 1;
        if (int'(in) < val) begin
          word = w(cnt + 1, int'(in));
          fval = val[15:0];
        end else begin
          word = w(cnt + 1, val);
          fval = in;
        end
        faddr = {a, (rw[23:16] < lw[23:16])};
      end
    end else begin
      pop = val[15:0];
      if (cnt == 0) begin
        eset = 1;
      end else if (cnt == 1) begin
        word = w(0, val);
      end else begin
        best = -1;
        for (int c = 0; c < 2; c++) begin
          if (ch[c][23:16] != 0) begin
            if (best < 0) best = c;
            else if (ch[c][15:0] < ch[best][15:0]) best = c;
          end
        end
        if (best < 0) best = 0;
        fwd = 1;
        word = w(cnt - 1, int'(ch[best][15:0]));
        faddr = {a, best[0]};
      end
    end
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic load(
    input logic [2:0] a, input logic [23:0] t,
    input logic [23:0] l, input logic [23:0] r
  );
    @(negedge clk);
    ld_en = 1;  ld_a = a;  ld_t = t;  ld_l = l;  ld_r = r;
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic do_op(
    input logic op, input logic [15:0] v, input logic [2:0] a,
    input int stall, input bit freeze
  );
    int wt, ic, k;
    bit done;
    o_we = 0;  o_popv = 0;  o_k = 0;  o_word = 0;
    o_fwd = 0;  o_fop = 0;  o_fval = 0;  o_pop = 0;  o_faddr = 0;
    o_unst = 0;  o_rbad = 0;  o_fbad = 0;
    @(negedge clk);
    wt = 0;
    while (!ready_out && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    up_in_val = 1;  up_in_op = op;  up_in = v;  up_in_addr = a;
    ready_in = (stall == 0);
    @(negedge clk);
    up_in_val = 0;
    k = 1;  ic = 0;  done = 0;
    while (!done && k < 40) begin
      if (freeze && k == 2) begin
        clk_en = 0;
        #1;
        if (tm_we || pop_dout_val) o_fbad = 1;
        repeat (2) begin
          @(negedge clk);
          #1;
          if (tm_we || pop_dout_val || idle_out) o_fbad = 1;
        end
        clk_en = 1;
        #1;
      end
      if (tm_we) begin
        o_we++;
        o_word = tm_dout;
      end
      if (pop_dout_val) begin
        o_popv++;
        o_pop = pop_dout;
      end
      if (low_out_val) begin
        if (ready_out) o_rbad = 1;
        if (!o_fwd) begin
          o_fwd = 1;  o_fop = low_out_op;
          o_fval = low_out;  o_faddr = low_out_addr;
        end else if ({low_out_op, low_out, low_out_addr} !=
                     {o_fop, o_fval, o_faddr}) begin
          o_unst = 1;
        end
        ic++;
        if (ic == stall + 1) ready_in = 1;
      end
      if (idle_out) done = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    o_k = k;
    ready_in = 1;
  endtask

  task automatic check_res(
    input logic op, input logic [2:0] a, input logic [23:0] node,
    input logic [23:0] word, input logic fwd,
    input logic [15:0] fval, input logic [3:0] faddr,
    input logic [15:0] pop, input int stall
  );
    logic [20:0] bus_a, bus_e;
    bus_a = {o_fop, op ? 16'd0 : o_fval, o_faddr};
    bus_e = fwd ? {op, op ? 16'd0 : fval, faddr} : 21'd0;
    chk("mem", tm_mem[a], word);
    chk("we_cnt", o_we, (word != node) ? 1 : 0);
    chk("fwd", o_fwd, fwd);
    chk("fwd_bus", bus_a, bus_e);
    chk("pop_val", o_popv, op);
    chk("pop_dout", o_pop, pop);
    chk("latency", o_k, fwd ? 4 + stall : 3);
    chk("hold", {o_unst, o_rbad, o_fbad}, 0);
  endtask

  int          lf_we, lf_ovf, lf_lov;

  task automatic leaf_ins(input logic [15:0] v);
    lf_we = 0;  lf_ovf = 0;  lf_lov = 0;
    @(negedge clk);
    b_up_in_val = 1;  b_up_in_op = 0;  b_up_in = v;  b_up_in_addr = 0;
    @(negedge clk);
    b_up_in_val = 0;
    repeat (5) begin
      if (b_tm_we) lf_we++;
      if (b_ovf) lf_ovf++;
      if (b_low_out_val) lf_lov++;
      @(negedge clk);
    end
  endtask

  vec_t tv [9];

  initial begin
    logic        rop, rfwd, reset_e;
    logic [15:0] rin, rfval, rpop;
    logic [2:0]  ra;
    logic [23:0] rnd, rlw, rrw, rword;
    logic [3:0]  rfa;
    int          rst_we, rstall;

    rst = 1;  clk_en = 1;  up_in_val = 0;  up_in_op = 0;
    up_in = 0;  up_in_addr = 0;  ready_in = 1;  child_idle_in = 1;
    b_up_in_val = 0;  b_up_in_op = 0;  b_up_in = 0;  b_up_in_addr = 0;
    ld_en = 0;  ld_a = 0;  ld_t = 0;  ld_l = 0;  ld_r = 0;
    err_exp = 0;

    tv[0] = mk(0, 5, 0, w(0,0), w(0,0), w(0,0), w(1,5), 0, 0, 0, 0);
    tv[1] = mk(0, 3, 0, w(2,5), w(1,8), w(0,0), w(3,3), 1, 5, 1, 0);
    tv[2] = mk(1, 0, 0, w(3,3), w(1,7), w(1,4), w(2,4), 1, 0, 1, 3);
    tv[3] = mk(0, 6, 5, w(1,6), w(0,0), w(0,0), w(2,6), 1, 6, 10, 0);
    tv[4] = mk(0, 9, 3, w(4,2), w(2,4), w(1,6), w(5,2), 1, 9, 7, 0);
    tv[5] = mk(1, 0, 7, w(1,11), w(0,0), w(0,0), w(0,11), 0, 0, 0, 11);
    tv[6] = mk(1, 0, 2, w(3,1), w(1,5), w(1,5), w(2,5), 1, 0, 4, 1);
    tv[7] = mk(1, 0, 6, w(2,4), w(0,0), w(1,9), w(1,9), 1, 0, 13, 4);
    tv[8] = mk(0, 1, 4, w(2,3), w(0,0), w(1,7), w(3,1), 1, 3, 8, 0);

    repeat (3) @(negedge clk);
    chk("rst_ready", ready_out, 0);
    chk("rst_idle", idle_out, 0);
    rst = 0;
    #1;
    chk("post_rst_idle", {idle_out, ready_out}, 2'b11);
    chk("post_rst_outs",
        {err, low_out_val, tm_we, pop_dout_val, ovf}, 0);

    for (int i = 0; i < 9; i++) begin
      load(tv[i].addr, tv[i].node, tv[i].lw, tv[i].rw);
      do_op(tv[i].op, tv[i].in, tv[i].addr, 0, 0);
      check_res(tv[i].op, tv[i].addr, tv[i].node, tv[i].word,
                tv[i].fwd, tv[i].fval, tv[i].faddr, tv[i].pop, 0);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom_range(0, 1));
      rin = 16'($urandom_range(0, 7));
      ra  = 3'($urandom_range(0, 7));
      rnd = w($urandom_range(0, 5), $urandom_range(0, 7));
      rlw = w($urandom_range(0, 2), $urandom_range(0, 7));
      rrw = w($urandom_range(0, 2), $urandom_range(0, 7));
      if (rlw[23:16] == 0 && rrw[23:16] == 0) rlw[23:16] = 8'd1;
      rstall = $urandom_range(0, 3);
      model(rop, rin, ra, rnd, rlw, rrw,
            rword, rfwd, rfval, rfa, rpop, reset_e);
      if (reset_e) err_exp = 1;
      load(ra, rnd, rlw, rrw);
      do_op(rop, rin, ra, rstall, ($urandom_range(0, 3) == 0));
      check_res(rop, ra, rnd, rword, rfwd, rfval, rfa, rpop, rstall);
      chk("err_sticky", err, err_exp);
    end

    load(0, w(2,5), w(1,8), w(0,0));
    do_op(0, 3, 0, 5, 0);
    check_res(0, 0, w(2,5), w(3,3), 1, 5, 1, 0, 5);

    load(4, w(0,0), w(0,0), w(0,0));
    do_op(1, 0, 4, 0, 0);
    chk("empty_pop_err", err, 1);
    chk("empty_pop_we", o_we, 0);
    chk("empty_pop_val", o_popv, 1);
    do_op(0, 2, 4, 0, 0);
    chk("err_stays", err, 1);
    chk("ins_after_err", tm_mem[4], w(1,2));

    load(1, w(0,0), w(0,0), w(0,0));
    @(negedge clk);
    up_in_val = 1;  up_in_op = 0;  up_in = 7;  up_in_addr = 1;
    @(negedge clk);
    up_in_val = 0;
    rst = 1;
    #1;
    chk("rst_rd_ready", {ready_out, idle_out}, 0);
    rst_we = 0;
    for (int c = 0; c < 5; c++) begin
      if (tm_we) rst_we++;
      @(negedge clk);
      if (c == 1) rst = 0;
    end
    chk("rst_rd_we", rst_we, 0);
    chk("rst_rd_err", err, 0);
    chk("rst_rd_idle", {idle_out, low_out_val}, 2'b10);
    chk("rst_rd_mem", tm_mem[1], w(0,0));
    err_exp = 0;

    load(0, w(0,0), w(0,0), w(0,0));
    leaf_ins(9);
    chk("leaf_empty", {8'(lf_we), b_mem[0]}, {8'd1, w(1,9)});
    chk("leaf_empty_ovf", lf_ovf, 0);
    leaf_ins(12);
    chk("leaf_win_mem", b_mem[0], w(1,12));
    chk("leaf_win_cnt", {8'(lf_we), 8'(lf_ovf), 8'(lf_lov)},
        {8'd1, 8'd1, 8'd0});
    leaf_ins(5);
    chk("leaf_lose_mem", b_mem[0], w(1,12));
    chk("leaf_lose_cnt", {8'(lf_we), 8'(lf_ovf), 8'(lf_lov)},
        {8'd0, 8'd1, 8'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
